// File: rtl/render_pkg.sv
// render_pkg: shared types for the render pipeline scan blocks.
//   vertex_t      screen-space vertex {x, y} at the default coordinate width
//   err_t         signed Bresenham error term, two bits wider than a coordinate
//   span_state_e  state encoding of the triangle span sequencer
package render_pkg;

    localparam int unsigned CORDW_DEF = 10;

    typedef struct packed {
        logic [CORDW_DEF-1:0] x;
        logic [CORDW_DEF-1:0] y;
    } vertex_t;

    typedef logic signed [CORDW_DEF+1:0] err_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SORT0,
        ST_SORT1,
        ST_SORT2,
        ST_INIT,
        ST_WALK_L,
        ST_WALK_S,
        ST_EMIT,
        ST_WAIT,
        ST_STEP,
        ST_FIN
    } span_state_e;

endpackage

// File: rtl/iter_tri_span_edge.sv
// iter_edge: integer Bresenham walker for one triangle edge, y non-decreasing.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load                capture endpoints (xs,ys)->(xe,ye); needs ye >= ys
//   xs, ys, xe, ye      edge endpoints
//   step                advance one pixel (ignored while load is high)
//   x, y                current pixel (registered)
//   next_y_changes      the next step moves to the following row
//   last                current pixel is the end point
module iter_edge
    import render_pkg::*;
#(
    parameter int unsigned CORDW = CORDW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CORDW-1:0] xs,
    input  logic [CORDW-1:0] ys,
    input  logic [CORDW-1:0] xe,
    input  logic [CORDW-1:0] ye,
    input  logic             step,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y,
    output logic             next_y_changes,
    output logic             last
);

    localparam int unsigned EW = CORDW + 2;

    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic signed [EW-1:0] err;
    logic [CORDW-1:0]     xe_r;
    logic [CORDW-1:0]     ye_r;
    logic                 sx_neg;

    logic [CORDW-1:0]     adx_c;
    logic [CORDW-1:0]     ady_c;
    logic signed [EW-1:0] dx_ld_c;
    logic signed [EW-1:0] dy_ld_c;
    logic signed [EW-1:0] e2_c;
    logic signed [EW-1:0] err_nxt_c;
    logic                 move_x_c;
    logic                 move_y_c;

    // Setup terms and the next error value; 2*err always fits in EW bits.
    always_comb begin
        adx_c     = (xe >= xs) ? (xe - xs) : (xs - xe);
        ady_c     = ye - ys;
        dx_ld_c   = $signed({2'b00, adx_c});
        dy_ld_c   = -$signed({2'b00, ady_c});
        e2_c      = err <<< 1;
        move_x_c  = (e2_c >= dy);
        move_y_c  = (e2_c <= dx);
        err_nxt_c = err;
        if (move_x_c) begin
            err_nxt_c = err_nxt_c + dy;
        end
        if (move_y_c) begin
            err_nxt_c = err_nxt_c + dx;
        end
    end

    assign next_y_changes = move_y_c;
    assign last           = (x == xe_r) && (y == ye_r);

    // Walker state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            xe_r   <= '0;
            ye_r   <= '0;
            sx_neg <= 1'b0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
        end else if (load) begin
            x      <= xs;
            y      <= ys;
            xe_r   <= xe;
            ye_r   <= ye;
            sx_neg <= (xe < xs);
            dx     <= dx_ld_c;
            dy     <= dy_ld_c;
            err    <= dx_ld_c + dy_ld_c;
        end else if (step) begin
            if (move_x_c) begin
                x <= sx_neg ? (x - CORDW'(1)) : (x + CORDW'(1));
            end
            if (move_y_c) begin
                y <= y + CORDW'(1);
            end
            err <= err_nxt_c;
        end
    end

endmodule

// File: rtl/iter_tri_span.sv
// iter_tri_span: filled-triangle scanline generator. Sorts three vertices by y,
// walks the long edge (A->C) and the short edges (A->B, B->C) row by row and
// emits one inclusive span per row, top to bottom.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       begin a triangle (accepted only when idle)
//   x0,y0,x1,y1,x2,y2           vertices, any order
//   span_done                   downstream finished the current span
//   sx0, sx1, sy                span left x, right x, row (registered)
//   span_start                  one-cycle pulse, span outputs valid
//   busy                        triangle in progress
//   done                        one-cycle pulse after the last span completes
module iter_tri_span
    import render_pkg::*;
#(
    parameter int unsigned CORDW = CORDW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] y0,
    input  logic [CORDW-1:0] x1,
    input  logic [CORDW-1:0] y1,
    input  logic [CORDW-1:0] x2,
    input  logic [CORDW-1:0] y2,
    input  logic             span_done,
    output logic [CORDW-1:0] sx0,
    output logic [CORDW-1:0] sx1,
    output logic [CORDW-1:0] sy,
    output logic             span_start,
    output logic             busy,
    output logic             done
);

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
    } vtx_t;

    span_state_e      state;
    vtx_t             va;
    vtx_t             vb;
    vtx_t             vc;
    logic             seg_bc;
    logic [CORDW-1:0] rmin;
    logic [CORDW-1:0] rmax;

    logic [CORDW-1:0] l_x;
    logic [CORDW-1:0] l_y;
    logic             l_nyc;
    logic             l_last;
    logic [CORDW-1:0] s_x;
    logic [CORDW-1:0] s_y;
    logic             s_nyc;
    logic             s_last;

    logic             load_l_c;
    logic             step_l_c;
    logic             load_s_c;
    logic             step_s_c;
    logic [CORDW-1:0] s_xs_c;
    logic [CORDW-1:0] s_ys_c;
    logic [CORDW-1:0] s_xe_c;
    logic [CORDW-1:0] s_ye_c;
    logic [CORDW-1:0] walk_x_c;
    logic [CORDW-1:0] min_c;
    logic [CORDW-1:0] max_c;

    // Edge control: an edge keeps stepping inside a row until its next step
    // would leave the row or it reaches its end; S reloads as B->C at B.
    always_comb begin
        load_l_c = (state == ST_INIT);
        step_l_c = (state == ST_STEP) ||
                   ((state == ST_WALK_L) && !l_last && !l_nyc);
        load_s_c = (state == ST_INIT) ||
                   ((state == ST_WALK_S) && s_last && !seg_bc);
        step_s_c = (state == ST_STEP) ||
                   ((state == ST_WALK_S) && !s_last && !s_nyc);
        if (state == ST_INIT) begin
            s_xs_c = va.x;
            s_ys_c = va.y;
            s_xe_c = vb.x;
            s_ye_c = vb.y;
        end else begin
            s_xs_c = vb.x;
            s_ys_c = vb.y;
            s_xe_c = vc.x;
            s_ye_c = vc.y;
        end
        walk_x_c = (state == ST_WALK_L) ? l_x : s_x;
        min_c    = (walk_x_c < rmin) ? walk_x_c : rmin;
        max_c    = (walk_x_c > rmax) ? walk_x_c : rmax;
    end

    iter_edge #(.CORDW(CORDW)) u_edge_l (
        .clk            (clk),
        .rst            (rst),
        .load           (load_l_c),
        .xs             (va.x),
        .ys             (va.y),
        .xe             (vc.x),
        .ye             (vc.y),
        .step           (step_l_c),
        .x              (l_x),
        .y              (l_y),
        .next_y_changes (l_nyc),
        .last           (l_last)
    );

    iter_edge #(.CORDW(CORDW)) u_edge_s (
        .clk            (clk),
        .rst            (rst),
        .load           (load_s_c),
        .xs             (s_xs_c),
        .ys             (s_ys_c),
        .xe             (s_xe_c),
        .ye             (s_ye_c),
        .step           (step_s_c),
        .x              (s_x),
        .y              (s_y),
        .next_y_changes (s_nyc),
        .last           (s_last)
    );

    // Span sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            va         <= '0;
            vb         <= '0;
            vc         <= '0;
            seg_bc     <= 1'b0;
            rmin       <= '1;
            rmax       <= '0;
            sx0        <= '0;
            sx1        <= '0;
            sy         <= '0;
            span_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            span_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        va    <= '{x: x0, y: y0};
                        vb    <= '{x: x1, y: y1};
                        vc    <= '{x: x2, y: y2};
                        busy  <= 1'b1;
                        state <= ST_SORT0;
                    end
                end
                // Strict compares keep tied vertices in input order.
                ST_SORT0: begin
                    if (vb.y < va.y) begin
                        va <= vb;
                        vb <= va;
                    end
                    state <= ST_SORT1;
                end
                ST_SORT1: begin
                    if (vc.y < vb.y) begin
                        vb <= vc;
                        vc <= vb;
                    end
                    state <= ST_SORT2;
                end
                ST_SORT2: begin
                    if (vb.y < va.y) begin
                        va <= vb;
                        vb <= va;
                    end
                    state <= ST_INIT;
                end
                ST_INIT: begin
                    seg_bc <= 1'b0;
                    rmin   <= '1;
                    rmax   <= '0;
                    state  <= ST_WALK_L;
                end
                ST_WALK_L: begin
                    rmin <= min_c;
                    rmax <= max_c;
                    if (l_last || l_nyc) begin
                        state <= ST_WALK_S;
                    end
                end
                // At B the walker reloads and the row keeps merging.
                ST_WALK_S: begin
                    rmin <= min_c;
                    rmax <= max_c;
                    if (s_last && !seg_bc) begin
                        seg_bc <= 1'b1;
                    end else if (s_last || s_nyc) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    sx0        <= rmin;
                    sx1        <= rmax;
                    sy         <= l_y;
                    span_start <= 1'b1;
                    state      <= ST_WAIT;
                end
                // Only the final row has the short edge sitting on C's row.
                ST_WAIT: begin
                    if (span_done) begin
                        state <= (s_y == vc.y) ? ST_FIN : ST_STEP;
                    end
                end
                ST_STEP: begin
                    rmin  <= '1;
                    rmax  <= '0;
                    state <= ST_WALK_L;
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_tri_span.sv
// tb_iter_tri_span: scoreboard bench for iter_tri_span. Stimulus pushes the
// hand-derived span list and expected done pulses; a monitor pops and compares
// on every span_start/done; a responder plays the downstream hline block.
module tb_iter_tri_span;

    localparam int unsigned CORDW = 10;

    typedef struct packed {
        logic [CORDW-1:0] lo;
        logic [CORDW-1:0] hi;
        logic [CORDW-1:0] row;
    } span_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CORDW-1:0] x0, y0, x1, y1, x2, y2;
    logic             span_done;
    logic [CORDW-1:0] sx0, sx1, sy;
    logic             span_start;
    logic             busy;
    logic             done;

    span_t exp_q[$];
    int    done_exp  = 0;
    int    n_tests   = 0;
    int    n_fail    = 0;
    int    bp_row    = -1;
    int    bp_cycles = 50;
    logic  bp_active = 1'b0;

    logic [CORDW-1:0] px[3] = '{10'd10, 10'd20, 10'd10};
    logic [CORDW-1:0] py[3] = '{10'd10, 10'd10, 10'd20};
    int perm[6][3] = '{'{0, 1, 2}, '{0, 2, 1}, '{1, 0, 2},
                       '{1, 2, 0}, '{2, 0, 1}, '{2, 1, 0}};

    always #5 clk = ~clk;

    iter_tri_span #(.CORDW(CORDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .span_done  (span_done),
        .sx0        (sx0),
        .sx1        (sx1),
        .sy         (sy),
        .span_start (span_start),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_span(input int lo, input int hi, input int row);
        exp_q.push_back('{lo: CORDW'(lo), hi: CORDW'(hi), row: CORDW'(row)});
    endtask

    // Flat-top triangle (10,10),(20,10),(10,20): row r spans 10..30-r.
    task automatic push_flat_top(input int last_row);
        for (int r = 10; r <= last_row; r++) begin
            push_span(10, 30 - r, r);
        end
    endtask

    task automatic start_tri(input int ax, input int ay, input int bx,
                             input int by, input int cx, input int cy);
        @(posedge clk); #1;
        x0 = CORDW'(ax); y0 = CORDW'(ay);
        x1 = CORDW'(bx); y1 = CORDW'(by);
        x2 = CORDW'(cx); y2 = CORDW'(cy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_tri(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || done_exp != 0) && cyc < 5000) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d spans pending, required 0", name, exp_q.size());
            exp_q.delete();
            done_exp = 0;
        end else begin
            check({name, "_busy_fall"}, 32'(busy), 32'd0);
        end
    endtask

    // Monitor: compare every presented span and done pulse with the scoreboard.
    initial begin
        span_t e;
        forever begin
            @(posedge clk); #1;
            if (span_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_span: got row %0d %0d..%0d, required none", sy, sx0, sx1);
                end else begin
                    e = exp_q.pop_front();
                    check("span_row", 32'(sy), 32'(e.row));
                    check("span_x0", 32'(sx0), 32'(e.lo));
                    check("span_x1", 32'(sx1), 32'(e.hi));
                end
            end
            if (done === 1'b1) begin
                n_tests++;
                if (done_exp == 0 || exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got done with %0d spans pending, %0d done expected", exp_q.size(), done_exp);
                end else begin
                    done_exp--;
                end
            end
        end
    end

    // Downstream responder: acknowledge each span, optionally stalling one row.
    initial begin
        span_t snap;
        logic  bad;
        span_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (span_start === 1'b1) begin
                if (int'(sy) == bp_row) begin
                    snap      = '{lo: sx0, hi: sx1, row: sy};
                    bad       = 1'b0;
                    bp_active = 1'b1;
                    repeat (bp_cycles) begin
                        @(posedge clk); #1;
                        if (sx0 !== snap.lo || sx1 !== snap.hi || sy !== snap.row ||
                            span_start !== 1'b0 || busy !== 1'b1) begin
                            bad = 1'b1;
                        end
                    end
                    check("backpressure_stable", 32'(bad), 32'd0);
                    bp_active = 1'b0;
                end else begin
                    @(posedge clk); #1;
                end
                span_done = 1'b1;
                @(posedge clk); #1;
                span_done = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sx0", 32'(sx0), 32'd0);
        check("reset_sx1", 32'(sx1), 32'd0);
        check("reset_sy", 32'(sy), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_span_start", 32'(span_start), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Flat top in all six vertex orders.
        for (int p = 0; p < 6; p++) begin
            push_flat_top(20);
            done_exp++;
            start_tri(int'(px[perm[p][0]]), int'(py[perm[p][0]]),
                      int'(px[perm[p][1]]), int'(py[perm[p][1]]),
                      int'(px[perm[p][2]]), int'(py[perm[p][2]]));
            wait_tri("flat_top");
        end

        // Shallow edge.
        push_span(0, 19, 0);
        push_span(0, 40, 1);
        done_exp++;
        start_tri(0, 0, 40, 1, 0, 1);
        wait_tri("shallow");

        // Degenerate single row.
        push_span(3, 9, 5);
        done_exp++;
        start_tri(3, 5, 9, 5, 7, 5);
        wait_tri("degenerate");

        // Backpressure at row 12 with an ignored start during the stall.
        bp_row = 12;
        push_flat_top(20);
        done_exp++;
        start_tri(10, 10, 20, 10, 10, 20);
        cyc = 0;
        while (bp_active !== 1'b1 && cyc < 500) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL backpressure_reach: got no stall at row %0d, required stall", bp_row);
        end else begin
            repeat (5) @(posedge clk);
            #1;
            x0 = 10'd3; y0 = 10'd5; x1 = 10'd9; y1 = 10'd5; x2 = 10'd7; y2 = 10'd5;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_tri("backpressure");
        bp_row = -1;
        repeat (20) @(posedge clk);

        // Reset during the third span: no done, no further spans.
        push_flat_top(12);
        start_tri(10, 10, 20, 10, 10, 20);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("third_span_reached", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("midreset_sx0", 32'(sx0), 32'd0);
        check("midreset_sx1", 32'(sx1), 32'd0);
        check("midreset_sy", 32'(sy), 32'd0);
        check("midreset_span_start", 32'(span_start), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);

        // Fresh triangle after the abort.
        push_span(0, 19, 0);
        push_span(0, 40, 1);
        done_exp++;
        start_tri(0, 0, 40, 1, 0, 1);
        wait_tri("after_reset");

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_tri_span.md
# iter_tri_span

Filled-triangle scanline generator for the render pipeline. Takes three screen-space vertices, walks the triangle's edges with integer Bresenham stepping, and emits one horizontal span per row, top to bottom. It sits directly upstream of `iter_hline`. `span_start`, `sx0` and `sx1` drive that block's `start`, `x0` and `x1`. Its `done` returns as `span_done`.

## Interface
Parameters:
- `CORDW`, default 10: coordinate width in bits, unsigned.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  begin a triangle; sampled only in IDLE
- `x0,y0,x1,y1,x2,y2`  in  CORDW each  vertices, any order; captured on accepted `start`
- `span_done`  in  1  one-cycle pulse from the downstream hline block: current span finished
- `sx0`  out  CORDW  span left x (inclusive)
- `sx1`  out  CORDW  span right x (inclusive), `sx1 >= sx0`
- `sy`  out  CORDW  span row
- `span_start`  out  1  one-cycle pulse: `sx0/sx1/sy` are valid
- `busy`  out  1  triangle in progress
- `done`  out  1  one-cycle pulse after the last span completes

## Operation
- **Sort.** Vertices are sorted ascending by y into A, B, C. The sort is 3 compare-swap cycles (A/B, B/C, A/B). Ties keep input order.
- **Edges.**
  - Long edge L runs A→C.
  - Short edge S runs A→B, then B→C.
- **Edge stepping.** Each edge uses standard Bresenham, with y always non-decreasing:
  - Setup: `dx=|xe-xs|`, `dy=-(ye-ys)`, `sx=±1`, `err=dx+dy`.
  - Each step: `e2=2*err`.
    - If `e2>=dy`: `err+=dy`, `x+=sx`.
    - If `e2<=dx`: `err+=dx`, `y+=1`.
  - The edge ends at the pixel equal to (xe, ye).
- **Width rule.** `err` and `e2` are signed, CORDW+2 bits; no overflow for any CORDW-bit vertex.
- **Per row r.**
  - Each edge walks every pixel it places on row r and tracks min x and max x.
  - Emitted span: `sx0 = min(Lmin, Smin)`, `sx1 = max(Lmax, Smax)`, `sy = r`.
- **Switching edges at row yB.** When S reaches B, it reloads as B→C and keeps merging into row yB. Row yB therefore includes pixels of both short edges.
- **Flat top (yA==yB).** The A→B segment still contributes row yA.
- **Flat bottom.** Handled naturally.
- **Degenerate (yA==yC).** Exactly one span, row yA, covering min..max of all three x.
- **Row count.** Rows run yA..yC inclusive: `yC-yA+1` spans, no gaps, no duplicates.

State machine:
- IDLE → SORT0 → SORT1 → SORT2 → INIT, then per row:
  - WALK_L: step L until its next step leaves the row or L ends.
  - WALK_S: same for S, including the B reload.
  - EMIT: pulse `span_start`.
  - WAIT: hold until `span_done`.
  - STEP: advance both edges onto the next row.
- From WAIT:
  - If `sy==yC`, go to FIN, which pulses `done` and returns to IDLE.
  - Otherwise go to STEP → WALK_L.

## Timing
- **Reset values:** all outputs 0; state IDLE. Reset mid-triangle aborts immediately. No `done` is issued, and no `span_start` follows the reset.
- **Busy:** `busy` rises the cycle after an accepted `start` and falls in the cycle `done` pulses.
- **Start while busy:** ignored, and the captured vertices are unchanged.
- **Span handshake:**
  - `sx0/sx1/sy` change only in EMIT and stay stable until the next EMIT.
  - Exactly one `span_done` is consumed per `span_start`.
  - `span_done` outside WAIT is ignored.
- **Latency:**
  - First `span_start` ≥ 6 cycles after `start`: 3 sort, 1 INIT, ≥1 WALK_L, ≥1 WALK_S.
  - Walking costs 1 cycle per edge pixel, with a minimum of 1 cycle per edge per row.
- **Done pulse:** `done` comes 1 cycle after the final `span_done`.

## Structure
- **Shared package `render_pkg`:**
  - `vertex_t` struct {x, y}, CORDW-wide.
  - Signed error type of CORDW+2 bits.
  - Span-FSM state enum.
- **Sub-module `iter_edge`**, one Bresenham walker instantiated twice (L and S):
  - Inputs: load, (xs,ys,xe,ye), step.
  - Outputs: x, y, `next_y_changes`, `last`.

## Test plan
- **Flat top.** (10,10),(20,10),(10,20) → 11 spans.
  - Row 10: 10..20. Row 15: 10..15. Row 20: 10..10.
  - Then `done`.
- **Permutation.** The same triangle fed in all 6 vertex orders → identical span sequence.
- **Shallow edge.** (0,0),(40,1),(0,1) → exactly two spans: row 0 0..19, then row 1 0..40.
- **Degenerate.** (3,5),(9,5),(7,5) → exactly one span, row 5 3..9, then `done`.
- **Backpressure.** Hold `span_done` low for 50 cycles at row 12 → `sx0/sx1/sy` stable, no extra `span_start`; a `start` pulse during this time is ignored.
- **Reset mid-walk.** Assert `rst` during the third span → all outputs 0 within the same cycle, no `done`. A new triangle started afterwards matches its reference span list.
